// File: rtl/mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_ctrl (with helper mult_NMbit)
// Description : Round-robin sequencer that time-shares one unsigned N x M
//               combinational array multiplier between two requesters.
//               Operands are registered, held for SETTLE_CYC cycles, and the
//               product is captured and returned over a valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================

// Unsigned shift-and-add array multiplier, purely combinational.
module mult_NMbit #(
  parameter int N = 4,
  parameter int M = 5
) (
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [N+M-1:0] p
);

  // Sum of the partial products a << i for every set bit of b
  always_comb begin
    p = '0;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p + ((N+M)'(a) << i);
    end
  end

endmodule

module mult_share_ctrl #(
  parameter int N          = 4,
  parameter int M          = 5,
  parameter int SETTLE_CYC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [M-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [M-1:0]   req1_b,
  output logic           resp0_valid,
  input  logic           resp0_ready,
  output logic           resp1_valid,
  input  logic           resp1_ready,
  output logic [N+M-1:0] resp_prod,
  output logic           busy,
  output logic           grant_id
);

  // A zero-cycle settle would sample the array in the same cycle the
  // operands land, which defeats the purpose of the settle interval.
  if (SETTLE_CYC < 1) begin : g_settle_chk
    $error("mult_share_ctrl: SETTLE_CYC must be >= 1");
  end

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   op_a;
  logic [M-1:0]   op_b;
  logic [CW-1:0]  cnt;
  logic           last_grant;
  logic           win;
  logic [N+M-1:0] array_p;

  mult_NMbit #(.N(N), .M(M)) u_mult (
    .a (op_a),
    .b (op_b),
    .p (array_p)
  );

  // Round-robin winner: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    if (req0_valid && req1_valid) win = ~last_grant;
    else                          win = req1_valid;
  end

  // Operand acceptance only in IDLE, only for the winner, never during reset
  always_comb begin
    req0_ready = !rst && (state == IDLE) && req0_valid && !win;
    req1_ready = !rst && (state == IDLE) && req1_valid &&  win;
  end

  // Sequencer: accept -> hold operands on the array -> capture -> respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      resp_prod   <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            op_a     <= win ? req1_a : req0_a;
            op_b     <= win ? req1_b : req0_b;
            grant_id <= win;
            cnt      <= CNT_LOAD;
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            resp_prod   <= array_p;
            resp0_valid <= ~grant_id;
            resp1_valid <=  grant_id;
            state       <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
            last_grant  <= grant_id;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
